fetch_control: RTL and testbench
================================

# fetch_control

Fetch-stage PC sequencer and F/D latch owner for the 5-stage pipeline. It consumes the redirect request and target produced by execute-stage branch resolution (`ctrl_branch`, `PCafterJump`), drives the instruction-memory address, and registers fetched instructions into the F/D latch. It also squashes wrong-path instructions and holds redirects that arrive during a pipeline stall. A saturating counter records applied redirects for performance debug.

## Interface
Parameters:
- `IMEM_AW`, default 12: instruction-memory address width. It equals the low bits of the PC.
- `RESET_PC`, default 32'd0: PC value loaded on reset.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `stall`  in  1  hazard/multdiv stall. Holds the PC and the F/D latch.
- `ctrl_branch`  in  1  redirect request from execute. Sampled every cycle.
- `PCafterJump`  in  32  redirect target. Qualified by `ctrl_branch`.
- `q_imem`  in  32  instruction at `address_imem`. Valid in the same cycle (combinational read).
- `address_imem`  out  IMEM_AW  equals PC[IMEM_AW-1:0].
- `fd_insn`  out  32  F/D latched instruction. Holds 32'd0 (nop) when invalid.
- `fd_PC`  out  32  PC+1 of the latched instruction. This is the base for branch-offset addition.
- `fd_valid`  out  1  F/D contents are a real instruction.
- `flush_dx`  out  1  combinational. When high, the D/X latch must load a nop in place of the decode instruction.
- `redirect_pending`  out  1  a redirect is held awaiting stall release.
- `branch_count`  out  32  number of applied redirects. Saturating.

## Operation
- Registered state: `PC`, `fd_insn`, `fd_PC`, `fd_valid`, `pend_target[31:0]`, `branch_count`, and the FSM state.
- FSM states:
  - RUN: no pending redirect.
  - PEND: a target is held. `redirect_pending = (state==PEND)`.
- Effective redirect: `redir = !stall && (ctrl_branch || state==PEND)`.
- Redirect target selection: `tgt = ctrl_branch ? PCafterJump : pend_target`. A fresh request overrides a held one.
- Each rising edge applies the first matching rule, in this priority order:
  1. `reset`: PC=RESET_PC, fd_insn=0, fd_PC=0, fd_valid=0, pend_target=0, branch_count=0, state=RUN.
  2. `redir`:
     - PC=tgt, fd_insn=0, fd_valid=0. fd_PC holds its value.
     - state=RUN.
     - branch_count += 1, saturating at 32'hFFFF_FFFF.
  3. `stall`:
     - PC, fd_insn, fd_PC and fd_valid all hold.
     - If ctrl_branch is high: pend_target=PCafterJump and state=PEND. A later request during the same stall overwrites the target.
     - branch_count is not incremented until the redirect is applied.
  4. Otherwise:
     - PC = PC+1 (32-bit, wraps from 32'hFFFF_FFFF to 0).
     - fd_insn=q_imem, fd_PC=PC+1, fd_valid=1.
- `flush_dx = redir && !reset`. It squashes the decode-stage instruction. Together with the nop load into F/D, a taken redirect kills exactly two wrong-path instructions.
- `address_imem` is a pure function of the registered PC. It has no combinational path from `ctrl_branch`.

## Timing
- Reset values of all outputs:
  - address_imem = RESET_PC[IMEM_AW-1:0].
  - fd_insn=0, fd_PC=0, fd_valid=0.
  - flush_dx=0, redirect_pending=0, branch_count=0.
- Fetch throughput: one instruction per cycle while stall is low.
- Redirect latency when not stalled:
  - ctrl_branch high in cycle N gives flush_dx=1 in cycle N.
  - address_imem=tgt in cycle N+1.
  - fd_insn = the target instruction with fd_valid=1 in cycle N+2.
- Redirect during stall:
  - flush_dx stays 0 while stall is high.
  - In the first cycle with stall low, flush_dx=1 and the held target is applied. Cycles then proceed as in the unstalled case from that point.
- If ctrl_branch and stall are high at the same time as reset, reset wins. The pending redirect is discarded.
- If stall falls in the same cycle that a new ctrl_branch arrives while in PEND, the new PCafterJump is used. Only one redirect is counted.

## Test plan
- Reset sequencing: reset for 2 cycles, then release with the imem returning `insn[i] = 32'hA000_0000 + i`.
  - address_imem must step 0,1,2.
  - fd_valid rises one cycle after release, with fd_insn=32'hA000_0000 and fd_PC=1.
- Unstalled redirect: ctrl_branch=1 with PCafterJump=32'd100 at PC=5.
  - flush_dx=1 in that cycle.
  - Next cycle: address_imem=100, fd_insn=0, fd_valid=0.
  - Following cycle: fd_insn=insn[100], fd_PC=101, branch_count=1.
- Redirect during stall: stall=1 for 3 cycles; pulse ctrl_branch with target 40 in stall cycle 1, then with target 60 in stall cycle 2.
  - redirect_pending must be 1 from the cycle after the first pulse.
  - PC must hold.
  - On stall release: flush_dx=1, then address_imem=60, branch_count incremented by exactly 1.
- Simultaneous release and new request: in PEND (target 40), drop stall and assert ctrl_branch with target 80 in the same cycle.
  - Next cycle: address_imem=80, redirect_pending=0, and branch_count rises by 1.
- Reset mid-operation: with state=PEND and stall=1, assert reset.
  - Next cycle: PC=0, redirect_pending=0, fd_valid=0, branch_count=0.
  - No redirect is applied after release.
- Wrap-around and saturation:
  - Force the PC via redirect to 32'hFFFF_FFFF, then run unstalled. The next PC must be 0 and fd_PC must be 0.
  - Preload branch_count near saturation through repeated redirects (or force it to 32'hFFFF_FFFE). Two more redirects must leave it at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/fetch_control.sv
// Fetch-stage PC sequencer and F/D latch owner: steps the PC, applies execute-stage
// redirects (holding ones that arrive during a stall) and counts applied redirects.
module fetch_control #(
    parameter int          IMEM_AW  = 12,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               ctrl_branch,
    input  logic [31:0]        PCafterJump,
    input  logic [31:0]        q_imem,
    output logic [IMEM_AW-1:0] address_imem,
    output logic [31:0]        fd_insn,
    output logic [31:0]        fd_PC,
    output logic               fd_valid,
    output logic               flush_dx,
    output logic               redirect_pending,
    output logic [31:0]        branch_count
);

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] fd_insn_reg;
    logic [31:0] fd_pc_reg;
    logic        fd_valid_reg;
    logic [31:0] pend_target_reg;
    logic [31:0] branch_count_reg;

    logic        redir;
    logic [31:0] tgt;
    logic [31:0] pc_inc;
    logic [31:0] count_next;

    // A fresh request in the release cycle overrides the held target.
    always_comb begin
        redir      = !stall && (ctrl_branch || (state_reg == PEND));
        tgt        = ctrl_branch ? PCafterJump : pend_target_reg;
        pc_inc     = pc_reg + 32'd1;
        count_next = (branch_count_reg == 32'hFFFF_FFFF) ? branch_count_reg
                                                         : branch_count_reg + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_reg           <= RESET_PC;
            fd_insn_reg      <= 32'd0;
            fd_pc_reg        <= 32'd0;
            fd_valid_reg     <= 1'b0;
            pend_target_reg  <= 32'd0;
            branch_count_reg <= 32'd0;
            state_reg        <= RUN;
        end else if (redir) begin
            // fd_PC keeps its value; only the instruction is squashed to a nop.
            pc_reg           <= tgt;
            fd_insn_reg      <= 32'd0;
            fd_valid_reg     <= 1'b0;
            branch_count_reg <= count_next;
            state_reg        <= RUN;
        end else if (stall) begin
            if (ctrl_branch) begin
                pend_target_reg <= PCafterJump;
                state_reg       <= PEND;
            end
        end else begin
            pc_reg       <= pc_inc;
            fd_insn_reg  <= q_imem;
            fd_pc_reg    <= pc_inc;
            fd_valid_reg <= 1'b1;
        end
    end

    // The imem address comes only from the registered PC, never from ctrl_branch.
    assign address_imem     = pc_reg[IMEM_AW-1:0];
    assign fd_insn          = fd_insn_reg;
    assign fd_PC            = fd_pc_reg;
    assign fd_valid         = fd_valid_reg;
    assign flush_dx         = redir && !reset;
    assign redirect_pending = (state_reg == PEND);
    assign branch_count     = branch_count_reg;

endmodule

// File: tb/tb_fetch_control.sv
// Bench for fetch_control: directed vector table, saturation sequence and random
// stimulus, all checked against a behavioural model of the fetch rules.
module tb_fetch_control;

    logic        clock = 1'b0;
    logic        reset, stall, ctrl_branch;
    logic [31:0] PCafterJump, q_imem;
    logic [11:0] address_imem;
    logic [31:0] fd_insn, fd_PC, branch_count;
    logic        fd_valid, flush_dx, redirect_pending;

    fetch_control #(.IMEM_AW(12), .RESET_PC(32'd0)) dut (
        .clock(clock), .reset(reset), .stall(stall), .ctrl_branch(ctrl_branch),
        .PCafterJump(PCafterJump), .q_imem(q_imem), .address_imem(address_imem),
        .fd_insn(fd_insn), .fd_PC(fd_PC), .fd_valid(fd_valid), .flush_dx(flush_dx),
        .redirect_pending(redirect_pending), .branch_count(branch_count)
    );

    always #5 clock = ~clock;

    // Instruction memory: insn[i] = A000_0000 + i.
    assign q_imem = 32'hA000_0000 + {20'd0, address_imem};

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    logic [31:0] m_pc, m_insn, m_fdpc, m_cnt, m_ptgt;
    logic        m_valid, m_pend;
    logic        flush_seen;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One clock: drive inputs, check combinational flush, advance the model, check state.
    task automatic drive(input logic r, input logic s, input logic cb, input logic [31:0] t);
        logic go;
        logic [31:0] dest;
        reset = r; stall = s; ctrl_branch = cb; PCafterJump = t;
        go   = !s && (cb || m_pend);
        dest = cb ? t : m_ptgt;
        #1;
        flush_seen = flush_dx;
        chk("flush_dx", 32'(flush_dx), 32'(go && !r));
        @(posedge clock);
        if (r) begin
            m_pc = 0; m_insn = 0; m_fdpc = 0; m_valid = 0; m_pend = 0; m_ptgt = 0; m_cnt = 0;
        end else if (go) begin
            m_pc = dest; m_insn = 0; m_valid = 0; m_pend = 0;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end else if (s) begin
            if (cb) begin m_pend = 1; m_ptgt = t; end
        end else begin
            m_insn = 32'hA000_0000 + (m_pc & 32'hFFF);
            m_pc = m_pc + 1;
            m_fdpc = m_pc;
            m_valid = 1;
        end
        #1;
        chk("address_imem", {20'd0, address_imem}, m_pc & 32'hFFF);
        chk("fd_insn", fd_insn, m_insn);
        chk("fd_PC", fd_PC, m_fdpc);
        chk("fd_valid", 32'(fd_valid), 32'(m_valid));
        chk("redirect_pending", 32'(redirect_pending), 32'(m_pend));
        chk("branch_count", branch_count, m_cnt);
    endtask

    typedef struct {
        logic r, s, cb;
        logic [31:0] tgt;
        logic e_flush;
        logic [31:0] e_addr, e_insn, e_fdpc;
        logic e_valid, e_pend;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    initial begin
        m_pc = 0; m_insn = 0; m_fdpc = 0; m_valid = 0; m_pend = 0; m_ptgt = 0; m_cnt = 0;
        reset = 1; stall = 0; ctrl_branch = 0; PCafterJump = 0;

        //               r  s  cb tgt            fl addr      insn           fdpc  v  p  cnt
        tbl.push_back('{1, 0, 0, 32'd0,        0, 32'd0,   32'd0,         32'd0,   0, 0, 32'd0});
        tbl.push_back('{1, 0, 1, 32'd55,       0, 32'd0,   32'd0,         32'd0,   0, 0, 32'd0});
        tbl.push_back('{0, 0, 0, 32'd0,        0, 32'd1,   32'hA000_0000, 32'd1,   1, 0, 32'd0});
        tbl.push_back('{0, 0, 0, 32'd0,        0, 32'd2,   32'hA000_0001, 32'd2,   1, 0, 32'd0});
        tbl.push_back('{0, 0, 0, 32'd0,        0, 32'd3,   32'hA000_0002, 32'd3,   1, 0, 32'd0});
        tbl.push_back('{0, 0, 0, 32'd0,        0, 32'd4,   32'hA000_0003, 32'd4,   1, 0, 32'd0});
        tbl.push_back('{0, 0, 0, 32'd0,        0, 32'd5,   32'hA000_0004, 32'd5,   1, 0, 32'd0});
        tbl.push_back('{0, 0, 1, 32'd100,      1, 32'd100, 32'd0,         32'd5,   0, 0, 32'd1});
        tbl.push_back('{0, 0, 0, 32'd0,        0, 32'd101, 32'hA000_0064, 32'd101, 1, 0, 32'd1});
        tbl.push_back('{0, 1, 1, 32'd40,       0, 32'd101, 32'hA000_0064, 32'd101, 1, 1, 32'd1});
        tbl.push_back('{0, 1, 1, 32'd60,       0, 32'd101, 32'hA000_0064, 32'd101, 1, 1, 32'd1});
        tbl.push_back('{0, 1, 0, 32'd0,        0, 32'd101, 32'hA000_0064, 32'd101, 1, 1, 32'd1});
        tbl.push_back('{0, 0, 0, 32'd0,        1, 32'd60,  32'd0,         32'd101, 0, 0, 32'd2});
        tbl.push_back('{0, 0, 0, 32'd0,        0, 32'd61,  32'hA000_003C, 32'd61,  1, 0, 32'd2});
        tbl.push_back('{0, 1, 1, 32'd40,       0, 32'd61,  32'hA000_003C, 32'd61,  1, 1, 32'd2});
        tbl.push_back('{0, 0, 1, 32'd80,       1, 32'd80,  32'd0,         32'd61,  0, 0, 32'd3});
        tbl.push_back('{0, 0, 0, 32'd0,        0, 32'd81,  32'hA000_0050, 32'd81,  1, 0, 32'd3});
        tbl.push_back('{0, 1, 1, 32'd7,        0, 32'd81,  32'hA000_0050, 32'd81,  1, 1, 32'd3});
        tbl.push_back('{1, 1, 1, 32'd9,        0, 32'd0,   32'd0,         32'd0,   0, 0, 32'd0});
        tbl.push_back('{0, 0, 0, 32'd0,        0, 32'd1,   32'hA000_0000, 32'd1,   1, 0, 32'd0});
        tbl.push_back('{0, 0, 0, 32'd0,        0, 32'd2,   32'hA000_0001, 32'd2,   1, 0, 32'd0});
        tbl.push_back('{0, 0, 1, 32'hFFFF_FFFF, 1, 32'hFFF, 32'd0,        32'd2,   0, 0, 32'd1});
        tbl.push_back('{0, 0, 0, 32'd0,        0, 32'd0,   32'hA000_0FFF, 32'd0,   1, 0, 32'd1});

        @(negedge clock);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].cb, tbl[i].tgt);
            chk("vec_flush", 32'(flush_seen), 32'(tbl[i].e_flush));
            chk("vec_addr", {20'd0, address_imem}, tbl[i].e_addr);
            chk("vec_insn", fd_insn, tbl[i].e_insn);
            chk("vec_fdpc", fd_PC, tbl[i].e_fdpc);
            chk("vec_valid", 32'(fd_valid), 32'(tbl[i].e_valid));
            chk("vec_pend", 32'(redirect_pending), 32'(tbl[i].e_pend));
            chk("vec_cnt", branch_count, tbl[i].e_cnt);
            $display("vec %0d: rst=%b stall=%b br=%b tgt=%h flush=%b addr=%h insn=%h fdpc=%h v=%b pend=%b cnt=%0d",
                     i, tbl[i].r, tbl[i].s, tbl[i].cb, tbl[i].tgt, flush_seen, address_imem,
                     fd_insn, fd_PC, fd_valid, redirect_pending, branch_count);
        end

        // Saturation: preload the counter just below the limit, then apply two redirects.
        force dut.branch_count_reg = 32'hFFFF_FFFE;
        #1;
        release dut.branch_count_reg;
        m_cnt = 32'hFFFF_FFFE;
        drive(0, 0, 1, 32'd3);
        chk("sat_first", branch_count, 32'hFFFF_FFFF);
        $display("sat redirect 1: cnt=%h", branch_count);
        drive(0, 0, 1, 32'd9);
        chk("sat_second", branch_count, 32'hFFFF_FFFF);
        $display("sat redirect 2: cnt=%h", branch_count);
        drive(0, 0, 0, 32'd0);
        drive(1, 0, 0, 32'd0);

        // Random stimulus against the model.
        for (int i = 0; i < 600; i++) begin
            logic r, s, cb;
            logic [31:0] t;
            r  = ($urandom_range(0, 63) == 0);
            s  = ($urandom_range(0, 2) == 0);
            cb = ($urandom_range(0, 4) == 0);
            t  = $urandom;
            drive(r, s, cb, t);
            $display("rnd %0d: rst=%b stall=%b br=%b tgt=%h flush=%b addr=%h v=%b pend=%b cnt=%0d",
                     i, r, s, cb, t, flush_seen, address_imem, fd_valid, redirect_pending, branch_count);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
